// File: rtl/q_pkg.sv
// Shared encodings and FIFO entry layout for the quantum timing/issue queue.
// Entry fields are sized to the widest supported configuration (QADDR_W <= 8, WAIT_W <= 32).
package q_pkg;

    localparam int unsigned MOP_W       = 5;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned QADDR_MAX_W = 8;
    localparam int unsigned WAIT_MAX_W  = 32;

    typedef enum logic [MOP_W-1:0] {
        QNOP  = 5'd0,
        X90   = 5'd1,
        X180  = 5'd2,
        Y90   = 5'd3,
        Y180  = 5'd4,
        Z90   = 5'd5,
        HAD   = 5'd6,
        CNOT  = 5'd7,
        CZ    = 5'd8,
        MEASZ = 5'd9
    } micro_op_e;

    // op_sel 2'b00 marks a timing-only entry that never reaches the output port
    typedef enum logic [SEL_W-1:0] {
        SEL_QNOP = 2'b00,
        SEL_1Q   = 2'b01,
        SEL_2Q   = 2'b10,
        SEL_MEAS = 2'b11
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    typedef struct packed {
        logic [MOP_W-1:0]       micro_op;
        logic [SEL_W-1:0]       op_sel;
        logic [QADDR_MAX_W-1:0] qaddr0;
        logic [QADDR_MAX_W-1:0] qaddr1;
        logic [WAIT_MAX_W-1:0]  wait_cycles;
    } q_entry_t;

endpackage

// File: rtl/q_issue_fifo.sv
// Synchronous FIFO of q_entry_t with occupancy count; DEPTH must be a power of 2.
// A push while full is dropped even if a pop happens in the same cycle.
module q_issue_fifo
    import q_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  q_entry_t               push_data,
    input  logic                   pop,
    output q_entry_t               head_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    q_entry_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rd_ptr];

    // Pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/q_timing_issue.sv
// Timed micro-op issue queue: FIFO of entries, each waits its relative delay then is issued.
// Optional Q_ISSUE_BYPASS_EN lets a zero-wait entry skip the FIFO when the queue is idle.
module q_timing_issue
    import q_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WAIT_W  = 16,
    parameter int unsigned QADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_micro_op,
    input  logic [1:0]             in_op_sel,
    input  logic [QADDR_W-1:0]     in_qaddr0,
    input  logic [QADDR_W-1:0]     in_qaddr1,
    input  logic [WAIT_W-1:0]      in_wait,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_micro_op,
    output logic [1:0]             out_op_sel,
    output logic [QADDR_W-1:0]     out_qaddr0,
    output logic [QADDR_W-1:0]     out_qaddr1,
    input  logic                   run,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   late,
    output logic                   idle
);

    state_e               state, state_d;
    logic [WAIT_W-1:0]    cnt, cnt_d;
    logic [4:0]           micro_op_d;
    logic [1:0]           op_sel_d;
    logic [QADDR_W-1:0]   qaddr0_d, qaddr1_d;
    logic                 valid_d, late_d;
    logic                 fifo_pop_c, fifo_push_c, bypass_c;
    logic                 fifo_full_c, fifo_empty_c;
    q_entry_t             in_entry, head_c;

    always_comb begin
        in_entry.micro_op    = in_micro_op;
        in_entry.op_sel      = in_op_sel;
        in_entry.qaddr0      = QADDR_MAX_W'(in_qaddr0);
        in_entry.qaddr1      = QADDR_MAX_W'(in_qaddr1);
        in_entry.wait_cycles = WAIT_MAX_W'(in_wait);
    end

`ifdef Q_ISSUE_BYPASS_EN
    assign bypass_c = (state == ST_IDLE) && fifo_empty_c && run && in_valid && (in_wait == '0);
`else
    assign bypass_c = 1'b0;
`endif

    assign in_ready    = !fifo_full_c;
    assign fifo_push_c = in_valid && in_ready && !bypass_c;
    assign idle        = (state == ST_IDLE) && fifo_empty_c;

    q_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_c),
        .push_data (in_entry),
        .pop       (fifo_pop_c),
        .head_c    (head_c),
        .count     (fifo_count),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // A finished timing-only entry behaves as if its output handshake completed at once
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (bypass_c)                   state_d = (in_op_sel != SEL_QNOP) ? ST_ISSUE : ST_IDLE;
                else if (run && !fifo_empty_c)  state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (run && cnt == '0) begin
                    if (out_op_sel != SEL_QNOP) state_d = ST_ISSUE;
                    else if (!fifo_empty_c)     state_d = ST_WAIT;
                    else                        state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (out_ready) state_d = (run && !fifo_empty_c) ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop_c = 1'b0;
        cnt_d      = cnt;
        micro_op_d = out_micro_op;
        op_sel_d   = out_op_sel;
        qaddr0_d   = out_qaddr0;
        qaddr1_d   = out_qaddr1;
        valid_d    = 1'b0;
        late_d     = late;
        unique case (state)
            ST_IDLE: begin
                if (bypass_c) begin
                    cnt_d      = '0;
                    micro_op_d = in_micro_op;
                    op_sel_d   = in_op_sel;
                    qaddr0_d   = in_qaddr0;
                    qaddr1_d   = in_qaddr1;
                    valid_d    = (in_op_sel != SEL_QNOP);
                end else if (run && !fifo_empty_c) begin
                    fifo_pop_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (run) begin
                    if (cnt != '0)                   cnt_d = cnt - WAIT_W'(1);
                    else if (out_op_sel != SEL_QNOP) valid_d = 1'b1;
                    else if (!fifo_empty_c)          fifo_pop_c = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!out_ready) begin
                    valid_d = 1'b1;
                    late_d  = 1'b1;
                end else if (run && !fifo_empty_c) begin
                    fifo_pop_c = 1'b1;
                end
            end
            default: ;
        endcase
        // Popped entry becomes the current entry; its fields sit on out_* while it waits
        if (fifo_pop_c) begin
            cnt_d      = WAIT_W'(head_c.wait_cycles);
            micro_op_d = head_c.micro_op;
            op_sel_d   = head_c.op_sel;
            qaddr0_d   = QADDR_W'(head_c.qaddr0);
            qaddr1_d   = QADDR_W'(head_c.qaddr1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_micro_op <= QNOP;
            out_op_sel   <= SEL_QNOP;
            out_qaddr0   <= '0;
            out_qaddr1   <= '0;
            late         <= 1'b0;
        end else begin
            cnt          <= cnt_d;
            out_valid    <= valid_d;
            out_micro_op <= micro_op_d;
            out_op_sel   <= op_sel_d;
            out_qaddr0   <= qaddr0_d;
            out_qaddr1   <= qaddr1_d;
            late         <= late_d;
        end
    end

endmodule
